char_attr_ram: RTL and testbench

- Per-character attribute store for the VGA text path; successor to the 1-bit blink store.
- Generalised to ATTR_W attribute bits per character:
  - bit0 blink
  - bit1 underline
  - bit2 inverse
  - bit3 conceal
  - higher bits are user-defined
- Adds an internal blink phase generator and a hardware bulk-fill engine.
- Single clock domain: system port and video port share sysclk_i.

---
 rtl/char_attr_ram.sv | 208 ++++++++++++++++++++
 tb/tb_char_attr_ram.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/char_attr_ram.sv
// Per-character attribute RAM for the VGA text path: system R/W port, 3-stage video read port,
// blink phase generator and a bulk-fill engine. Define ATTR_FRAME_BLINK_EN for vsync-based blink.
module char_attr_ram #(
    parameter int CHAR_NUM       = 2400,
    parameter int ATTR_W         = 4,
    parameter int SYS_DW         = 8,
    parameter int SYS_AW         = 11,
    parameter int VADDR_W        = 12,
    parameter int BLINK_DIV      = 24,
    parameter int BLINK_FRAMES   = 30,
    parameter     INIT_FILE_NAME = "",
    parameter     INIT_ENABLE    = "DISABLE"
) (
    input  logic               sysclk_i,
    input  logic               rst_i,
    input  logic [SYS_AW-1:0]  attr_addr_i,
    input  logic [SYS_DW-1:0]  attr_data_i,
    input  logic               attr_wren_i,
    output logic [SYS_DW-1:0]  attr_data_o,
    input  logic               fill_start_i,
    input  logic [ATTR_W-1:0]  fill_value_i,
    output logic               fill_busy_o,
    input  logic               vsync_i,
    input  logic [VADDR_W-1:0] vaddress_i,
    output logic [ATTR_W-1:0]  vattr_o,
    output logic               vblink_o,
    output logic               vhide_o,
    output logic               blink_phase_o
);
    localparam int CPW    = SYS_DW / ATTR_W;
    localparam int WORDS  = CHAR_NUM / CPW;
    localparam int WA     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int WSH    = $clog2(CPW);
    localparam int SLOT_W = (CPW > 1) ? WSH : 1;
    localparam int STAGES = 2;

    localparam logic [SYS_AW-1:0]  WORDS_A = SYS_AW'(WORDS);
    localparam logic [VADDR_W-1:0] CHAR_V  = VADDR_W'(CHAR_NUM);
    localparam logic [WA-1:0]      LAST_W  = WA'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_t;

    logic [SYS_DW-1:0] mem [WORDS];

    // ---------------- blink phase ----------------
    logic phase_q, phase_d;

`ifdef ATTR_FRAME_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unused_blink_div = BLINK_DIV;
    logic          vs_q;
    logic [FW-1:0] frm_q, frm_d;

    always_comb begin
        frm_d   = frm_q;
        phase_d = phase_q;
        if (vsync_i && !vs_q) begin
            if (frm_q == FW'(BLINK_FRAMES - 1)) begin
                frm_d   = '0;
                phase_d = !phase_q;
            end else begin
                frm_d = frm_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            vs_q    <= 1'b0;
            frm_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            vs_q    <= vsync_i;
            frm_q   <= frm_d;
            phase_q <= phase_d;
        end
    end
`else
    localparam int unused_blink_frames = BLINK_FRAMES;
    logic                 unused_vsync;
    logic [BLINK_DIV-1:0] bcnt_q, bcnt_d;

    assign unused_vsync = vsync_i;
    assign bcnt_d       = bcnt_q + 1'b1;
    assign phase_q      = bcnt_q[BLINK_DIV-1];
    assign phase_d      = bcnt_d[BLINK_DIV-1];

    always_ff @(posedge sysclk_i) begin
        if (rst_i) bcnt_q <= '0;
        else       bcnt_q <= bcnt_d;
    end
`endif

    assign blink_phase_o = phase_q;

    // ---------------- fill engine ----------------
    fill_state_t       state_q, state_d;
    logic [WA-1:0]     ptr_q, ptr_d;
    logic [ATTR_W-1:0] fval_q, fval_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        fval_d  = fval_q;
        case (state_q)
            IDLE: begin
                if (fill_start_i) begin
                    state_d = FILL;
                    ptr_d   = '0;
                    fval_d  = fill_value_i;
                end
            end
            FILL: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST_W) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            fval_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            fval_q  <= fval_d;
        end
    end

    assign fill_busy_o = (state_q == FILL);

    // ---------------- single write port ----------------
    logic              fill_we, sys_we, mem_we;
    logic [WA-1:0]     mem_waddr;
    logic [SYS_DW-1:0] mem_wdata;

    // A start pulse in IDLE claims the port on the same edge, so the system write loses.
    always_comb begin
        fill_we   = (state_q == FILL);
        sys_we    = attr_wren_i && !fill_busy_o && (attr_addr_i < WORDS_A)
                    && !((state_q == IDLE) && fill_start_i);
        mem_we    = !rst_i && (fill_we || sys_we);
        mem_waddr = fill_we ? ptr_q : attr_addr_i[WA-1:0];
        mem_wdata = fill_we ? {CPW{fval_q}} : attr_data_i;
    end

    always_ff @(posedge sysclk_i) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // ---------------- system read ----------------
    logic [SYS_AW-1:0] sys_addr_q;

    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            sys_addr_q  <= '0;
            attr_data_o <= '0;
        end else begin
            sys_addr_q  <= attr_addr_i;
            attr_data_o <= (sys_addr_q < WORDS_A) ? mem[sys_addr_q[WA-1:0]] : '0;
        end
    end

    // ---------------- video read ----------------
    logic [STAGES:0]    vld_pipe;
    logic [VADDR_W-1:0] vaddr_q;
    logic [SYS_DW-1:0]  vword_q;
    logic [SLOT_W-1:0]  vslot_q, vslot_d;
    logic [ATTR_W-1:0]  vsel;

    assign vld_pipe[0] = (vaddress_i < CHAR_V);

    generate
        if (CPW > 1) begin : g_slot
            assign vslot_d = vaddr_q[SLOT_W-1:0];
        end else begin : g_noslot
            assign vslot_d = '0;
        end
    endgenerate

    assign vsel = vld_pipe[2] ? vword_q[vslot_q*ATTR_W +: ATTR_W] : '0;

    // vhide uses the phase after this edge so it always equals vblink_o & blink_phase_o.
    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            vld_pipe[STAGES:1] <= '0;
            vaddr_q            <= '0;
            vword_q            <= '0;
            vslot_q            <= '0;
            vattr_o            <= '0;
            vblink_o           <= 1'b0;
            vhide_o            <= 1'b0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            vaddr_q            <= vaddress_i;
            vword_q            <= mem[vaddr_q[WSH +: WA]];
            vslot_q            <= vslot_d;
            vattr_o            <= vsel;
            vblink_o           <= vsel[0];
            vhide_o            <= vsel[0] & phase_d;
        end
    end

endmodule

// File: tb/tb_char_attr_ram.sv
// Directed self-checking bench for char_attr_ram (ATTR_W=4, BLINK_DIV=4, BLINK_FRAMES=3).
module tb_char_attr_ram;
    logic        sysclk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [10:0] attr_addr_i = '0;
    logic [7:0]  attr_data_i = '0;
    logic        attr_wren_i = 1'b0;
    logic [7:0]  attr_data_o;
    logic        fill_start_i = 1'b0;
    logic [3:0]  fill_value_i = '0;
    logic        fill_busy_o;
    logic        vsync_i = 1'b0;
    logic [11:0] vaddress_i = '0;
    logic [3:0]  vattr_o;
    logic        vblink_o, vhide_o, blink_phase_o;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    char_attr_ram #(.BLINK_DIV(4), .BLINK_FRAMES(3)) dut (
        .sysclk_i(sysclk_i), .rst_i(rst_i),
        .attr_addr_i(attr_addr_i), .attr_data_i(attr_data_i), .attr_wren_i(attr_wren_i),
        .attr_data_o(attr_data_o),
        .fill_start_i(fill_start_i), .fill_value_i(fill_value_i), .fill_busy_o(fill_busy_o),
        .vsync_i(vsync_i), .vaddress_i(vaddress_i),
        .vattr_o(vattr_o), .vblink_o(vblink_o), .vhide_o(vhide_o), .blink_phase_o(blink_phase_o)
    );

    always #5 sysclk_i = ~sysclk_i;

    // Cycles since the last reset edge; timebase for the expected blink phase.
    always @(posedge sysclk_i) cyc <= rst_i ? 0 : cyc + 1;

    function automatic logic exp_phase();
`ifdef ATTR_FRAME_BLINK_EN
        return 1'b0;
`else
        return cyc[3];
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sysclk_i);
        @(negedge sysclk_i);
    endtask

    task automatic wr(input logic [10:0] a, input logic [7:0] d);
        attr_addr_i = a; attr_data_i = d; attr_wren_i = 1'b1;
        step();
        attr_wren_i = 1'b0;
    endtask

    task automatic rd(input logic [10:0] a, output logic [7:0] d);
        attr_addr_i = a; attr_wren_i = 1'b0;
        step(); step();
        d = attr_data_o;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (fill_busy_o && n < 2000) begin
            step();
            n++;
        end
        if (n >= 2000) chk("fill_timeout", 32'(n), 32'd1999);
    endtask

    logic [11:0] va [5] = '{12'd10, 12'd11, 12'd12, 12'd13, 12'd2400};
    logic [3:0]  ea [5] = '{4'h5, 4'hA, 4'hC, 4'h3, 4'h0};

    initial begin
        logic [7:0] d;
        int n;

        // Reset state
        step(); step();
        chk("rst_data", 32'(attr_data_o), 0);
        chk("rst_vattr", 32'(vattr_o), 0);
        chk("rst_vblink", 32'(vblink_o), 0);
        chk("rst_vhide", 32'(vhide_o), 0);
        chk("rst_phase", 32'(blink_phase_o), 0);
        chk("rst_busy", 32'(fill_busy_o), 0);
        rst_i = 1'b0;

        // Blink phase: toggles every 8 cycles (free-running) or stays 0 (frame mode)
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("phase_run", 32'(blink_phase_o), 32'(exp_phase()));
        end

        // System write/read with latency and read-new-data
        wr(11'd5, 8'hA5);
        attr_addr_i = 11'd6; attr_data_i = 8'h3C; attr_wren_i = 1'b1;
        step();
        attr_wren_i = 1'b0;
        chk("rd_new_data", 32'(attr_data_o), 32'hA5);
        attr_addr_i = 11'd5;
        step();
        chk("rd_lat1", 32'(attr_data_o), 32'h3C);
        step();
        chk("rd_lat2", 32'(attr_data_o), 32'hA5);

        // Video pipeline: back-to-back addresses, 3-cycle latency, out of range -> 0
        for (int i = 0; i < 7; i++) begin
            if (i < 5) vaddress_i = va[i];
            step();
            if (i >= 2) begin
                chk("vattr", 32'(vattr_o), 32'(ea[i-2]));
                chk("vblink", 32'(vblink_o), 32'(ea[i-2][0]));
                chk("vhide_seq", 32'(vhide_o), 32'(ea[i-2][0] & exp_phase()));
            end
        end

        // Full fill with 0x3; start coincides with a write, a second start and a write mid-fill
        fill_start_i = 1'b1; fill_value_i = 4'h3;
        attr_addr_i = 11'd0; attr_data_i = 8'h77; attr_wren_i = 1'b1;
        step();
        fill_start_i = 1'b0; attr_wren_i = 1'b0; fill_value_i = 4'hF;
        chk("fill_busy_start", 32'(fill_busy_o), 1);
        n = 0;
        while (fill_busy_o && n < 2000) begin
            if (n == 10) begin
                fill_start_i = 1'b1; fill_value_i = 4'h5;
                attr_addr_i = 11'd1; attr_data_i = 8'h99; attr_wren_i = 1'b1;
            end else begin
                fill_start_i = 1'b0; attr_wren_i = 1'b0;
            end
            step();
            n++;
        end
        fill_start_i = 1'b0; attr_wren_i = 1'b0;
        chk("fill_len", 32'(n), 32'd1200);
        rd(11'd0, d);    chk("fill_w0", 32'(d), 32'h33);
        rd(11'd1, d);    chk("fill_w1", 32'(d), 32'h33);
        rd(11'd600, d);  chk("fill_w600", 32'(d), 32'h33);
        rd(11'd1199, d); chk("fill_w1199", 32'(d), 32'h33);

        // Preload 0x00, then abort a 0x1 fill with reset at fill cycle 100
        fill_start_i = 1'b1; fill_value_i = 4'h0;
        step();
        fill_start_i = 1'b0;
        wait_idle(n);
        step();
        fill_start_i = 1'b1; fill_value_i = 4'h1;
        attr_addr_i = 11'd1100; attr_data_i = 8'h77; attr_wren_i = 1'b1;
        step();
        fill_start_i = 1'b0; attr_wren_i = 1'b0;
        chk("abort_busy_on", 32'(fill_busy_o), 1);
        repeat (100) step();
        rst_i = 1'b1;
        step();
        chk("abort_busy_off", 32'(fill_busy_o), 0);
        rst_i = 1'b0;
        rd(11'd0, d);    chk("abort_w0", 32'(d), 32'h11);
        rd(11'd99, d);   chk("abort_w99", 32'(d), 32'h11);
        rd(11'd100, d);  chk("abort_w100", 32'(d), 32'h00);
        rd(11'd1100, d); chk("abort_w1100", 32'(d), 32'h00);
        rd(11'd1199, d); chk("abort_w1199", 32'(d), 32'h00);

        // vhide follows the phase only for a blink-attribute character
        wr(11'd5, 8'h01);
        vaddress_i = 12'd10;
        repeat (3) step();
        for (int k = 0; k < 20; k++) begin
            chk("vhide_blink", 32'(vhide_o), 32'(exp_phase()));
            chk("phase_hold", 32'(blink_phase_o), 32'(exp_phase()));
            step();
        end
        vaddress_i = 12'd11;
        repeat (3) step();
        for (int k = 0; k < 16; k++) begin
            chk("vhide_plain", 32'(vhide_o), 0);
            step();
        end

`ifdef ATTR_FRAME_BLINK_EN
        // Frame blink: toggle on every 3rd rising edge of vsync
        for (int p = 1; p <= 8; p++) begin
            vsync_i = 1'b1; step();
            vsync_i = 1'b0; step(); step();
            chk("frame_phase", 32'(blink_phase_o), 32'((p >= 3 && p < 6) ? 1 : 0));
        end
        vsync_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("frame_hold", 32'(blink_phase_o), 1);
        end
        vsync_i = 1'b0;
        step(); step();
        chk("frame_release", 32'(blink_phase_o), 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
